// File: rtl/wdt_cmd_push_ctrl_if.sv
// Requester handshake and async-FIFO write port bundle for wdt_cmd_push_ctrl.
// The master modport is the controller side; slave is the requester/FIFO side.
interface wdt_cmd_push_ctrl_if #(
    parameter int NUM_REQ   = 3,
    parameter int PAYLOAD_W = 32
);
    localparam int ID_W = ($clog2(NUM_REQ) < 1) ? 1 : $clog2(NUM_REQ);

    logic [NUM_REQ-1:0]           req_valid;
    logic [NUM_REQ*PAYLOAD_W-1:0] req_data;
    logic [NUM_REQ-1:0]           req_ready;
    logic                         fifo_wpush;
    logic [ID_W+PAYLOAD_W-1:0]    fifo_wdata;
    logic                         fifo_wfull;

    modport master (
        input  req_valid,
        input  req_data,
        input  fifo_wfull,
        output req_ready,
        output fifo_wpush,
        output fifo_wdata
    );

    modport slave (
        output req_valid,
        output req_data,
        output fifo_wfull,
        input  req_ready,
        input  fifo_wpush,
        input  fifo_wdata
    );
endinterface

// File: rtl/wdt_cmd_push_ctrl.sv
// Round-robin command arbiter and paced push sequencer for the WDT async FIFO.
// Optional push counter output enabled by defining WDT_CMD_PUSH_CNT_EN.
module wdt_cmd_push_ctrl #(
    parameter int NUM_REQ     = 3,
    parameter int PAYLOAD_W   = 32,
    parameter int STALL_LIMIT = 1024
) (
    input  logic                       wclk,
    input  logic                       wrst,
    wdt_cmd_push_ctrl_if.master        bus,
    output logic                       busy,
    output logic                       stall_err,
    input  logic                       err_clr
`ifdef WDT_CMD_PUSH_CNT_EN
    ,
    output logic [15:0]                push_cnt
`endif
);
    localparam int ID_W  = ($clog2(NUM_REQ) < 1) ? 1 : $clog2(NUM_REQ);
    localparam int CNT_W = $clog2(STALL_LIMIT);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STALL_LIMIT - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PUSH = 2'd1,
        GAP  = 2'd2
    } state_e;

    state_e                      state_q, state_d;
    logic [ID_W-1:0]             last_q, last_d;
    logic [ID_W+PAYLOAD_W-1:0]   hold_q, hold_d;
    logic [CNT_W-1:0]            stall_cnt_q, stall_cnt_d;
    logic                        stall_err_q, stall_err_d;

    logic                        grant_vld;
    logic [ID_W-1:0]             grant_id;
    logic [ID_W:0]               cand;
    logic [PAYLOAD_W-1:0]        grant_pl;

    // Search starts one past the last grant so no requester starves.
    always_comb begin
        grant_vld = 1'b0;
        grant_id  = '0;
        cand      = '0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            cand = {1'b0, last_q} + (ID_W+1)'(i);
            if (cand >= (ID_W+1)'(NUM_REQ))
                cand = cand - (ID_W+1)'(NUM_REQ);
            if (!grant_vld && bus.req_valid[cand[ID_W-1:0]]) begin
                grant_vld = 1'b1;
                grant_id  = cand[ID_W-1:0];
            end
        end
    end

    always_comb begin
        grant_pl = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant_id == ID_W'(i))
                grant_pl = bus.req_data[i*PAYLOAD_W +: PAYLOAD_W];
        end
    end

    always_ff @(posedge wclk or posedge wrst) begin
        if (wrst) begin
            state_q     <= IDLE;
            last_q      <= ID_W'(NUM_REQ - 1);
            hold_q      <= '0;
            stall_cnt_q <= '0;
            stall_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            last_q      <= last_d;
            hold_q      <= hold_d;
            stall_cnt_q <= stall_cnt_d;
            stall_err_q <= stall_err_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        last_d      = last_q;
        hold_d      = hold_q;
        stall_cnt_d = stall_cnt_q;
        unique case (state_q)
            IDLE: begin
                if (grant_vld) begin
                    state_d = PUSH;
                    last_d  = grant_id;
                    hold_d  = {grant_id, grant_pl};
                end
            end
            PUSH: begin
                if (!bus.fifo_wfull) begin
                    state_d     = GAP;
                    stall_cnt_d = '0;
                end else if (stall_cnt_q != CNT_MAX) begin
                    stall_cnt_d = stall_cnt_q + 1'b1;
                end
            end
            GAP:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Set has priority over clear; re-arms every full cycle at saturation.
    always_comb begin
        stall_err_d = stall_err_q;
        if (err_clr)
            stall_err_d = 1'b0;
        if (state_q == PUSH && bus.fifo_wfull && stall_cnt_d == CNT_MAX)
            stall_err_d = 1'b1;
    end

    always_comb begin
        bus.req_ready  = '0;
        bus.fifo_wpush = 1'b0;
        if (state_q == IDLE && grant_vld) begin
            for (int i = 0; i < NUM_REQ; i++)
                bus.req_ready[i] = (grant_id == ID_W'(i));
        end
        if (state_q == PUSH)
            bus.fifo_wpush = ~bus.fifo_wfull;
        bus.fifo_wdata = hold_q;
        busy           = (state_q != IDLE);
        stall_err      = stall_err_q;
    end

`ifdef WDT_CMD_PUSH_CNT_EN
    logic [15:0] push_cnt_q, push_cnt_d;

    always_comb begin
        push_cnt_d = push_cnt_q;
        if (err_clr)
            push_cnt_d = '0;
        else if (bus.fifo_wpush && push_cnt_q != 16'hFFFF)
            push_cnt_d = push_cnt_q + 16'd1;
    end

    always_ff @(posedge wclk or posedge wrst) begin
        if (wrst)
            push_cnt_q <= '0;
        else
            push_cnt_q <= push_cnt_d;
    end

    assign push_cnt = push_cnt_q;
`endif

endmodule

// File: tb/tb_wdt_cmd_push_ctrl.sv
// Scoreboard bench for wdt_cmd_push_ctrl: predicted {id,payload} queued at
// accept, popped and compared whenever the DUT pushes.
module tb_wdt_cmd_push_ctrl;
    localparam int NR = 3;
    localparam int PW = 32;
    localparam int IW = 2;
    localparam int SL = 8;

    logic wclk = 1'b0;
    logic wrst;
    logic err_clr;
    logic busy;
    logic stall_err;
`ifdef WDT_CMD_PUSH_CNT_EN
    logic [15:0] push_cnt;
`endif

    wdt_cmd_push_ctrl_if #(.NUM_REQ(NR), .PAYLOAD_W(PW)) bus ();

    wdt_cmd_push_ctrl #(
        .NUM_REQ(NR),
        .PAYLOAD_W(PW),
        .STALL_LIMIT(SL)
    ) dut (
        .wclk(wclk),
        .wrst(wrst),
        .bus(bus),
        .busy(busy),
        .stall_err(stall_err),
        .err_clr(err_clr)
`ifdef WDT_CMD_PUSH_CNT_EN
        ,
        .push_cnt(push_cnt)
`endif
    );

    always #5 wclk = ~wclk;

    int checks = 0;
    int errors = 0;
    int model_last;
    logic [IW+PW-1:0] sbq[$];
    logic [PW-1:0] pl[NR];

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    function automatic int rr_pick(input logic [NR-1:0] v);
        for (int i = 1; i <= NR; i++) begin
            int c = (model_last + i) % NR;
            if (v[c]) return c;
        end
        return 0;
    endfunction

    always @(negedge wclk) begin
        if (!wrst && bus.fifo_wpush) begin
            logic [IW+PW-1:0] e;
            chk("push_while_full", bus.fifo_wfull, 0);
            chk("sb_nonempty", sbq.size() > 0, 1);
            if (sbq.size() > 0) begin
                e = sbq.pop_front();
                chk("wdata", bus.fifo_wdata, e);
            end
        end
    end

    task automatic tick();
        @(posedge wclk);
        #1;
    endtask

    // Enters in an IDLE cycle just after the edge, returns in the next IDLE.
    task automatic send_cmd(input logic [NR-1:0] m, input bit keep);
        int g;
        logic [IW+PW-1:0] e;
        bus.req_data   = {pl[2], pl[1], pl[0]};
        bus.req_valid  = m;
        bus.fifo_wfull = 1'b0;
        @(negedge wclk);
        g = rr_pick(m);
        chk("ready_accept", bus.req_ready, 64'(1) << g);
        chk("busy_idle", busy, 0);
        e = {IW'(g), pl[g]};
        sbq.push_back(e);
        model_last = g;
        tick();
        if (!keep) bus.req_valid = '0;
        @(negedge wclk);
        chk("push_cycle", bus.fifo_wpush, 1);
        chk("ready_push", bus.req_ready, 0);
        chk("busy_push", busy, 1);
        tick();
        @(negedge wclk);
        chk("gap_nopush", bus.fifo_wpush, 0);
        chk("gap_wdata", bus.fifo_wdata, e);
        chk("ready_gap", bus.req_ready, 0);
        chk("busy_gap", busy, 1);
        tick();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL timeout got 0 exp 1");
        $fatal(1, "timeout");
    end

    initial begin
        logic [IW+PW-1:0] e;
        int g;
        wrst           = 1'b1;
        err_clr        = 1'b0;
        bus.req_valid  = '0;
        bus.req_data   = '0;
        bus.fifo_wfull = 1'b0;
        model_last     = NR - 1;
        pl[0] = 32'h0000_0001;
        pl[1] = 32'hBBBB_0002;
        pl[2] = 32'hCCCC_0003;

        @(negedge wclk);
        chk("rst_ready", bus.req_ready, 0);
        chk("rst_wpush", bus.fifo_wpush, 0);
        chk("rst_wdata", bus.fifo_wdata, 0);
        chk("rst_busy", busy, 0);
        chk("rst_stall_err", stall_err, 0);
        tick();
        wrst = 1'b0;
        tick();

        // single command from requester 0
        send_cmd(3'b001, 1'b0);
        @(negedge wclk);
        chk("busy_after", busy, 0);
        tick();

        // all requesters valid: strict rotation, one push per 3 cycles
        pl[0] = 32'hAAAA_0001;
        repeat (9) send_cmd(3'b111, 1'b1);
        bus.req_valid = '0;

        // short back-pressure: no push, hold stable, no error
        bus.req_valid  = 3'b010;
        bus.fifo_wfull = 1'b1;
        @(negedge wclk);
        g = rr_pick(3'b010);
        chk("ready_full", bus.req_ready, 64'(1) << g);
        e = {IW'(g), pl[g]};
        sbq.push_back(e);
        model_last = g;
        tick();
        bus.req_valid = '0;
        for (int k = 1; k <= 5; k++) begin
            @(negedge wclk);
            chk("full_nopush", bus.fifo_wpush, 0);
            chk("full_hold", bus.fifo_wdata, e);
            chk("stall_short", stall_err, 0);
            tick();
        end
        bus.fifo_wfull = 1'b0;
        @(negedge wclk);
        chk("push_after_full", bus.fifo_wpush, 1);
        tick();
        @(negedge wclk);
        chk("gap_after_full", bus.fifo_wpush, 0);
        chk("stall_short_end", stall_err, 0);
        tick();

        // long back-pressure: sticky error, clear ignored while set fires
        bus.req_valid  = 3'b100;
        bus.fifo_wfull = 1'b1;
        @(negedge wclk);
        g = rr_pick(3'b100);
        chk("ready_stall", bus.req_ready, 64'(1) << g);
        sbq.push_back({IW'(g), pl[g]});
        model_last = g;
        tick();
        bus.req_valid = '0;
        for (int k = 1; k <= 20; k++) begin
            @(negedge wclk);
            chk("stall_err_k", stall_err, (k >= SL));
            chk("stall_nopush", bus.fifo_wpush, 0);
            tick();
            err_clr = (k == 9);
        end
        bus.fifo_wfull = 1'b0;
        @(negedge wclk);
        chk("stall_push", bus.fifo_wpush, 1);
        chk("stall_err_held", stall_err, 1);
        tick();
        err_clr = 1'b1;
        @(negedge wclk);
        chk("stall_err_gap", stall_err, 1);
        tick();
        err_clr = 1'b0;
        @(negedge wclk);
        chk("stall_err_clr", stall_err, 0);
        tick();

        // reset during a full stall discards the held command
        bus.req_valid  = 3'b001;
        bus.fifo_wfull = 1'b1;
        @(negedge wclk);
        g = rr_pick(3'b001);
        chk("ready_prerst", bus.req_ready, 64'(1) << g);
        model_last = g;
        tick();
        bus.req_valid = '0;
        @(negedge wclk);
        chk("prerst_nopush", bus.fifo_wpush, 0);
        tick();
        wrst = 1'b1;
        @(negedge wclk);
        chk("midrst_wpush", bus.fifo_wpush, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_wdata", bus.fifo_wdata, 0);
        tick();
        wrst = 1'b0;
        bus.fifo_wfull = 1'b0;
        model_last = NR - 1;
        send_cmd(3'b111, 1'b0);

        // ten commands with random request masks
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        for (int n = 0; n < 10; n++) begin
            pl[n % NR] = $urandom;
            send_cmd(NR'($urandom_range(1, 7)), 1'b0);
        end
`ifdef WDT_CMD_PUSH_CNT_EN
        @(negedge wclk);
        chk("push_cnt_10", push_cnt, 10);
        tick();
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        @(negedge wclk);
        chk("push_cnt_clr", push_cnt, 0);
        tick();
`endif

        @(negedge wclk);
        chk("sb_empty", sbq.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
